// File: rtl/prod_accum_if.sv
// Product-side handshake between the shift-add multiplier and prod_accum.
// The master (multiplier) drives in_valid/in_prod, and the slave (accumulator) drives in_ready.
interface prod_accum_if #(
    parameter int SIZE = 8
);
    logic                in_valid;
    logic [2*SIZE-1:0]   in_prod;
    logic                in_ready;

    modport master (
        output in_valid,
        output in_prod,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        output in_ready
    );
endinterface

// File: rtl/prod_accum.sv
// prod_accum: multiply-accumulate back end that sums TERMS unsigned products per frame.
// Optional build macro PROD_ACCUM_SATURATE_EN: when defined, acc_out clamps at 2^ACC_W-1
// on overflow and stays clamped for the rest of the frame; otherwise acc_out wraps.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results of the last frame are held
// ACCUM | accepting products; start here restarts the frame
// DONE  | single-cycle acc_valid strobe; start and in_valid are ignored
module prod_accum #(
    parameter int SIZE  = 8,
    parameter int TERMS = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    prod_accum_if.slave      prod_bus,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    output logic             busy,
    output logic [7:0]       term_cnt,
    output logic             overflow
);

    localparam int         PROD_W = 2 * SIZE;
    localparam int         SUM_W  = ACC_W + 1;
    localparam logic [7:0] LAST   = 8'(TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             in_ready;
    logic             xfer;
    logic             clear;
    logic             last_xfer;
    logic [SUM_W-1:0] prod_ext;
    logic [SUM_W-1:0] sum_ext;
    logic             carry;

    // A product presented in the same cycle as a restart is dropped, so start masks the transfer.
    assign xfer      = prod_bus.in_valid & in_ready & ~start;
    assign clear     = start & ((state == IDLE) || (state == ACCUM));
    assign last_xfer = xfer & (term_cnt == LAST);

    assign prod_ext = SUM_W'(prod_bus.in_prod);
    assign sum_ext  = {1'b0, acc_out} + prod_ext;
    assign carry    = sum_ext[ACC_W];

    assign prod_bus.in_ready = in_ready;

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (last_xfer) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decode the registered state only, never in_valid.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        acc_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                acc_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                busy      = 1'b0;
                acc_valid = 1'b0;
            end
        endcase
    end

    // Accumulator, term counter and sticky overflow; all hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out  <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            acc_out  <= '0;
            term_cnt <= '0;
            overflow <= 1'b0;
        end else if (xfer) begin
            term_cnt <= term_cnt + 8'd1;
            overflow <= overflow | carry;
`ifdef PROD_ACCUM_SATURATE_EN
            if (overflow || carry) begin
                acc_out <= '1;
            end else begin
                acc_out <= sum_ext[ACC_W-1:0];
            end
`else
            acc_out <= sum_ext[ACC_W-1:0];
`endif
        end
    end

endmodule
